// File: rtl/gate_stim_seq.sv
// Truth-table stimulus sequencer for a two-input AND gate: walks a/b through
// 00,01,10,11, samples gate_out at the end of each dwell and flags mismatches.
module gate_stim_seq #(
  parameter int unsigned DWELL_CYCLES = 50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       gate_out,
  output logic       a,
  output logic       b,
  output logic [1:0] vec_idx,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_vec
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL_CYCLES - 1);

  if (DWELL_CYCLES < 2 || DWELL_CYCLES > 65535) begin : g_bad_dwell
    $error("gate_stim_seq: DWELL_CYCLES must be in 2..65535");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       fail_upd_c;

  // fail_vec with the current vector's result folded in, used on the sample edge
  always_comb begin
    fail_upd_c          = fail_vec;
    fail_upd_c[vec_idx] = gate_out != (a & b);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      a        <= 1'b0;
      b        <= 1'b0;
      vec_idx  <= 2'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      fail_vec <= 4'b0000;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= RUN;
            cnt      <= '0;
            a        <= 1'b0;
            b        <= 1'b0;
            vec_idx  <= 2'd0;
            busy     <= 1'b1;
            done     <= 1'b0;
            pass     <= 1'b0;
            fail_vec <= 4'b0000;
          end
        end
        RUN: begin
          if (cnt == LAST_CNT) begin
            cnt      <= '0;
            fail_vec <= fail_upd_c;
            if (vec_idx == 2'd3) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (fail_upd_c == 4'b0000);
            end else begin
              vec_idx <= vec_idx + 2'd1;
              a       <= (vec_idx + 2'd1) >> 1 != 2'd0;
              b       <= ~vec_idx[0];
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
